// File: rtl/uart_tx_drain.sv
// Purpose: drains bytes from an upstream FIFO and sends them as 8N1 UART frames (LSB first).
// Latency: read strobe -> first start-bit cycle is 2 cycles; a frame lasts 10*CLKS_PER_BIT cycles.
// Backpressure: reads only when idle, enabled, CTS asserted and FIFO non-empty; a started frame always completes unless reset.
module uart_tx_drain #(
  parameter int CLKS_PER_BIT = 217,
  parameter int WIDTH        = 9
) (
  input  logic             i_clk,
  input  logic             i_rst,
  output logic             o_fifo_rd_en,
  input  logic [WIDTH-1:0] i_fifo_rd_data,
  input  logic             i_fifo_rd_valid,
  input  logic             i_fifo_empty,
  input  logic             i_enable,
  input  logic             i_cts_n,
  output logic             o_tx,
  output logic             o_busy,
  output logic             o_tx_done
);

  localparam int BAUD_W = $clog2(CLKS_PER_BIT);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FETCH = 3'd1;
  localparam logic [2:0] S_START = 3'd2;
  localparam logic [2:0] S_DATA  = 3'd3;
  localparam logic [2:0] S_STOP  = 3'd4;

  logic [2:0]        state_q, state_d;
  logic [BAUD_W-1:0] baud_q, baud_d;
  logic [2:0]        bit_q, bit_d;
  logic [7:0]        shift_q, shift_d;
  logic              tx_q, tx_d;
  logic              armed_q;
  logic              baud_last;
  logic              start_rd;
  logic              unused_rd_data;

  // Only the low byte is transmitted; upper FIFO bits are deliberately dropped.
  assign unused_rd_data = ^i_fifo_rd_data;

  assign baud_last = (baud_q == BAUD_LAST);

  // armed_q holds off the first read until a clock edge has been seen out of reset.
  assign start_rd = (state_q == S_IDLE) & armed_q & i_enable & ~i_cts_n & ~i_fifo_empty;

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    case (state_q)
      S_IDLE: begin
        baud_d = '0;
        bit_d  = '0;
        if (start_rd) begin
          state_d = S_FETCH;
        end
      end
      S_FETCH: begin
        baud_d = '0;
        bit_d  = '0;
        if (i_fifo_rd_valid) begin
          shift_d = i_fifo_rd_data[7:0];
          state_d = S_START;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_START: begin
        if (baud_last) begin
          baud_d  = '0;
          bit_d   = '0;
          state_d = S_DATA;
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
      S_DATA: begin
        if (baud_last) begin
          baud_d = '0;
          bit_d  = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
            state_d = S_STOP;
          end
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
      S_STOP: begin
        if (baud_last) begin
          baud_d  = '0;
          state_d = S_IDLE;
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        baud_d  = '0;
        bit_d   = '0;
      end
    endcase
  end

  // Line level is computed from the next state so the registered output lines up with the state.
  always_comb begin
    tx_d = 1'b1;
    case (state_d)
      S_START: tx_d = 1'b0;
      S_DATA:  tx_d = shift_d[bit_d];
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= S_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
      armed_q <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
      armed_q <= 1'b1;
    end
  end

  assign o_fifo_rd_en = start_rd;
  assign o_tx         = tx_q;
  assign o_busy       = (state_q != S_IDLE);
  assign o_tx_done    = (state_q == S_STOP) & baud_last;

endmodule

// File: tb/tb_uart_tx_drain.sv
// Randomized scoreboard bench for uart_tx_drain: FIFO model feeds bytes, a line monitor decodes frames.
module tb_uart_tx_drain;

  localparam int CPB   = 4;
  localparam int W     = 9;
  localparam int FRAME = 10 * CPB;

  logic         clk      = 1'b0;
  logic         rst      = 1'b0;
  logic         rd_en;
  logic [W-1:0] rd_data  = '0;
  logic         rd_valid = 1'b0;
  logic         empty    = 1'b1;
  logic         enable   = 1'b0;
  logic         cts_n    = 1'b1;
  logic         tx;
  logic         busy;
  logic         done;

  always #5 clk = ~clk;

  uart_tx_drain #(.CLKS_PER_BIT(CPB), .WIDTH(W)) dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .o_fifo_rd_en   (rd_en),
    .i_fifo_rd_data (rd_data),
    .i_fifo_rd_valid(rd_valid),
    .i_fifo_empty   (empty),
    .i_enable       (enable),
    .i_cts_n        (cts_n),
    .o_tx           (tx),
    .o_busy         (busy),
    .o_tx_done      (done)
  );

  int tests = 0;
  int fails = 0;

  logic [W-1:0] fifo[$];
  logic [7:0]   exp_q[$];
  int drop_req  = 0;
  int drop_done = 0;

  int cyc = 0, rd_cnt = 0, rd_cyc_last = -100, rd_cyc_prev = -100;
  int done_cnt = 0, frames = 0, last_end = -100, last_gap = -1, aborts = 0, low_cnt = 0;
  bit in_frame = 1'b0;
  int idx = 0;
  logic smp  [FRAME];
  logic dsmp [FRAME];

  task automatic check(input string name, input int act, input int req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  // Compare one captured frame against the next expected byte: waveform and done pulse.
  task automatic score_frame();
    logic [7:0] e;
    logic [7:0] got;
    logic       lvl;
    int         bad, dbad, b;
    for (int i = 0; i < 8; i++) got[i] = smp[(i + 1) * CPB + CPB / 2];
    tests++;
    if (exp_q.size() == 0) begin
      fails++;
      $display("FAIL frame_unexpected: got byte 0x%02h, required no frame", got);
      return;
    end
    e = exp_q.pop_front();
    bad  = 0;
    dbad = 0;
    for (int i = 0; i < FRAME; i++) begin
      b   = i / CPB;
      lvl = (b == 0) ? 1'b0 : (b == 9) ? 1'b1 : e[b - 1];
      if (smp[i] !== lvl) bad++;
      if (dsmp[i] !== (i == FRAME - 1)) dbad++;
    end
    if (bad != 0) begin
      fails++;
      $display("FAIL frame_wave: got byte 0x%02h (%0d bad samples), required 0x%02h", got, bad, e);
    end
    check("frame_done_pulse_bad_samples", dbad, 0);
  endtask

  // Upstream FIFO model: data valid the cycle after the strobe, optional forced miss.
  initial begin : fifo_model
    logic         take;
    logic [W-1:0] w;
    take = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      rd_valid = 1'b0;
      rd_data  = W'($urandom);
      if (take) begin
        if (drop_req > drop_done) begin
          drop_done++;
        end else if (fifo.size() > 0) begin
          w        = fifo.pop_front();
          rd_valid = 1'b1;
          rd_data  = w;
          exp_q.push_back(w[7:0]);
        end
      end
      empty = (fifo.size() == 0);
      @(negedge clk);
      take = rd_en;
    end
  end

  initial begin : line_monitor
    forever begin
      @(negedge clk);
      cyc++;
      if (tx === 1'b0) low_cnt++;
      if (rd_en) begin
        rd_cnt++;
        rd_cyc_prev = rd_cyc_last;
        rd_cyc_last = cyc;
        check("rd_en_only_when_idle_busy", int'(busy), 0);
      end
      if (done) done_cnt++;
      if (rst) begin
        if (in_frame) begin
          in_frame = 1'b0;
          aborts++;
          if (exp_q.size() > 0) void'(exp_q.pop_front());
        end
      end else begin
        if (!in_frame && tx === 1'b0) begin
          in_frame = 1'b1;
          idx      = 0;
          last_gap = cyc - last_end - 1;
        end
        if (in_frame) begin
          smp[idx]  = tx;
          dsmp[idx] = done;
          idx++;
          if (idx == FRAME) begin
            in_frame = 1'b0;
            last_end = cyc;
            frames++;
            score_frame();
          end
        end
      end
    end
  end

  task automatic drain(input int budget);
    int  n;
    bit  ok;
    n  = 0;
    ok = 1'b0;
    while (!ok && n < budget) begin
      @(negedge clk);
      n++;
      ok = (fifo.size() == 0) && (exp_q.size() == 0) && !busy && !in_frame;
    end
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL drain_timeout: got %0d queued bytes after %0d cycles, required 0", fifo.size() + exp_q.size(), n);
    end
  endtask

  task automatic wait_start(input int budget);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (tx !== 1'b0 && n < budget);
    check("start_bit_seen", int'(tx === 1'b0), 1);
  endtask

  initial begin : stim
    int r0, f0, d0, l0, n;
    #1 rst = 1'b1;
    #2;
    check("rst_tx", int'(tx), 1);
    check("rst_busy", int'(busy), 0);
    check("rst_rd_en", int'(rd_en), 0);
    check("rst_done", int'(done), 0);

    // 0xA5 queued while in reset; upper FIFO bit set to show it is ignored.
    fifo.push_back(9'h1A5);
    enable = 1'b1;
    cts_n  = 1'b0;
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    #1 check("rd_en_before_first_edge", int'(rd_en), 0);
    @(posedge clk);
    #1 check("rd_en_first_edge", int'(rd_en), 1);
    drain(200);
    check("a5_rd_en_count", rd_cnt, 1);
    check("a5_done_count", done_cnt, 1);
    check("a5_frames", frames, 1);

    // Back-to-back 0x00, 0xFF.
    r0 = rd_cnt; f0 = frames;
    fifo.push_back(9'h000);
    fifo.push_back(9'h0FF);
    drain(300);
    check("pair_rd_en_count", rd_cnt - r0, 2);
    check("pair_frames", frames - f0, 2);
    check("pair_gap_cycles", last_gap, 2);

    // CTS deasserted holds off reads.
    cts_n = 1'b1;
    @(posedge clk);
    #1;
    r0 = rd_cnt; l0 = low_cnt;
    fifo.push_back(9'h13C);
    repeat (50) @(posedge clk);
    #1;
    check("cts_hold_rd_en", rd_cnt - r0, 0);
    check("cts_hold_tx_low_samples", low_cnt - l0, 0);
    cts_n = 1'b0;
    @(negedge clk);
    check("cts_release_rd_en", int'(rd_en), 1);
    drain(200);

    // Missed fetch: retried right after returning to idle.
    r0 = rd_cnt; f0 = frames; d0 = done_cnt;
    drop_req++;
    fifo.push_back(9'h0C3);
    drain(200);
    check("miss_rd_en_count", rd_cnt - r0, 2);
    check("miss_rd_en_spacing", rd_cyc_last - rd_cyc_prev, 2);
    check("miss_frames", frames - f0, 1);
    check("miss_done_count", done_cnt - d0, 1);

    // Reset during DATA bit 3 (byte 0xE7 has bit 3 low).
    fifo.push_back(9'h1E7);
    wait_start(100);
    repeat (17) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("midframe_rst_tx", int'(tx), 1);
    check("midframe_rst_busy", int'(busy), 0);
    check("midframe_rst_done", int'(done), 0);
    r0 = rd_cnt; d0 = done_cnt;
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (30) @(posedge clk);
    #1;
    check("midframe_rst_no_reread", rd_cnt - r0, 0);
    check("midframe_rst_no_done", done_cnt - d0, 0);
    check("midframe_rst_byte_lost", exp_q.size(), 0);
    check("midframe_rst_aborts", aborts, 1);

    // Enable dropped during START: current frame finishes, no further reads.
    r0 = rd_cnt; f0 = frames;
    fifo.push_back(9'h05A);
    fifo.push_back(9'h196);
    wait_start(100);
    @(posedge clk);
    #1 enable = 1'b0;
    repeat (60) @(posedge clk);
    #1;
    check("en_drop_rd_en_count", rd_cnt - r0, 1);
    check("en_drop_frames", frames - f0, 1);
    check("en_drop_fifo_left", fifo.size(), 1);
    enable = 1'b1;
    drain(200);

    // Random traffic with CTS toggling and occasional missed fetches.
    for (int it = 0; it < 25; it++) begin
      n = $urandom_range(1, 3);
      for (int k = 0; k < n; k++) fifo.push_back(W'($urandom));
      if ($urandom_range(0, 3) == 0) drop_req++;
      if ($urandom_range(0, 1) == 1) begin
        cts_n = 1'b1;
        repeat ($urandom_range(1, 12)) @(posedge clk);
        #1 cts_n = 1'b0;
      end
      repeat ($urandom_range(0, 30)) @(posedge clk);
      #1;
    end
    drain(25 * 3 * 50 + 500);
    repeat (4) @(negedge clk);

    check("total_done_vs_frames", done_cnt, frames);
    check("total_rd_en_vs_outcomes", rd_cnt, frames + aborts + drop_done);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: got no completion, required finish before 1000000");
    fails++;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1);
  end

endmodule

// File: doc/uart_tx_drain.md
UART_TX_DRAIN -- requirements
Module: uart_tx_drain

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 217, clock cycles per serial bit (minimum 2).
REQ-002 SHALL have parameter WIDTH, default 9, width of the FIFO read-data word.
REQ-003 SHALL have port i_clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port i_rst  input  1  reset, asynchronous and active-high.
REQ-005 SHALL have port o_fifo_rd_en  output  1  read strobe to the upstream FIFO.
REQ-006 SHALL have port i_fifo_rd_data  input  WIDTH  FIFO read data, valid the cycle after the strobe.
REQ-007 SHALL have port i_fifo_rd_valid  input  1  qualifies i_fifo_rd_data.
REQ-008 SHALL have port i_fifo_empty  input  1  FIFO empty status.
REQ-009 SHALL have port i_enable  input  1  transmitter enable.
REQ-010 SHALL have port i_cts_n  input  1  clear-to-send, active-low, already synchronous to i_clk.
REQ-011 SHALL have port o_tx  output  1  serial line, idle high.
REQ-012 SHALL have port o_busy  output  1  high whenever state is not IDLE.
REQ-013 SHALL have port o_tx_done  output  1  one-cycle pulse at the end of each stop bit.

Function
REQ-014 SHALL implement the states IDLE, FETCH, START, DATA and STOP.
REQ-015 IDLE: when i_enable=1, i_cts_n=0 and i_fifo_empty=0, SHALL assert o_fifo_rd_en for exactly one cycle and go to FETCH.
REQ-016 o_fifo_rd_en SHALL never be asserted outside the IDLE-to-FETCH transition cycle.
REQ-017 FETCH (one cycle): if i_fifo_rd_valid=1, SHALL latch i_fifo_rd_data[7:0] into the shift register and go to START; otherwise SHALL return to IDLE with no frame sent.
REQ-018 i_fifo_rd_data bits above bit 7 SHALL be ignored.
REQ-019 START SHALL drive o_tx=0 for CLKS_PER_BIT cycles, starting the cycle after FETCH.
REQ-020 DATA SHALL drive 8 bits LSB first, each for CLKS_PER_BIT cycles, using a 3-bit bit index.
REQ-021 STOP SHALL drive o_tx=1 for CLKS_PER_BIT cycles.
REQ-022 In the last STOP cycle, o_tx_done SHALL pulse high and the block SHALL go to IDLE.
REQ-023 The baud counter SHALL be $clog2(CLKS_PER_BIT) bits wide, count 0..CLKS_PER_BIT-1, and clear on every bit boundary.
REQ-024 o_tx SHALL be registered, with no combinational path from any input.
REQ-025 A frame SHALL occupy 10*CLKS_PER_BIT cycles from the first START cycle to the last STOP cycle.
REQ-026 Back-to-back frames SHALL be separated by exactly one IDLE cycle plus one FETCH cycle, both with o_tx=1.
REQ-027 i_enable and i_cts_n SHALL be sampled only in IDLE; deasserting either mid-frame SHALL NOT abort the frame.
REQ-028 i_fifo_empty rising during FETCH SHALL have no effect; only i_fifo_rd_valid decides the FETCH outcome.
REQ-029 o_busy SHALL be 0 in IDLE and 1 in FETCH, START, DATA and STOP.

Reset
REQ-030 While i_rst=1, the block SHALL immediately (asynchronously) drive o_tx=1, o_fifo_rd_en=0, o_busy=0 and o_tx_done=0, set state to IDLE, and clear the baud counter, bit index and shift register to 0.
REQ-031 Reset asserted mid-frame SHALL abandon the frame; the byte SHALL be lost and SHALL NOT be re-read.
REQ-032 After reset deasserts, the first o_fifo_rd_en SHALL occur no earlier than the first rising edge with i_rst=0.

Verification (bench CLKS_PER_BIT=4)
REQ-033 FIFO holds 0xA5, enable=1, cts_n=0 -> one rd_en pulse, then o_tx sequence 0,1,0,1,0,0,1,0,1,1 with each level held 4 cycles, then o_tx_done pulses once.
REQ-034 FIFO holds 0x00 and 0xFF -> two frames, 2 idle-high cycles between the stop bit of the first and the start bit of the second, and exactly 2 rd_en pulses in total.
REQ-035 i_cts_n=1 with a non-empty FIFO for 50 cycles -> no rd_en and o_tx=1 throughout; cts_n falling -> rd_en on the next edge.
REQ-036 rd_en issued but i_fifo_rd_valid=0 in FETCH -> return to IDLE, o_tx stays 1, o_tx_done stays 0, next attempt issued one cycle later.
REQ-037 i_rst pulsed during DATA bit 3 -> o_tx=1 and o_busy=0 within the same cycle, before any clock edge, and no o_tx_done.
REQ-038 i_enable dropped during START -> the frame completes normally and no further rd_en is issued.
